// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - host-to-flash command sequencer (read, program, erase) over a single-cycle bridge
// Issues the flash command/poll/clear cycles for each host operation and reports data, status and error.
module flash_cmd_seq #(
  parameter logic [15:0] POLL_MAX = 16'd50000,
  parameter logic [1:0]  GAP      = 2'd1
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       op_start,
  input  logic [1:0] op_code,
  input  logic [7:0] op_addr,
  input  logic [7:0] op_wdata,
  output logic       op_busy,
  output logic       op_done,
  output logic [7:0] op_rdata,
  output logic       op_err,
  output logic [7:0] op_status,
  output logic       br_req,
  output logic       br_we,
  output logic [7:0] br_addr,
  output logic [7:0] br_wdata,
  input  logic [7:0] br_rdata,
  input  logic       br_ack
);

  typedef enum logic [2:0] {IDLE, CMD1, CMD2, POLL, CLR, ARRAY, RDARR, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  code_q;
  logic [7:0]  addr_q, wdata_q, rdata_q, status_q;
  logic        req, err_q, done_q;
  logic [1:0]  gap_cnt;
  logic [15:0] poll_cnt, poll_inc;
  logic        bus_state, ack, gap_ok, status_err, poll_timeout;

  assign bus_state    = (state == CMD1) || (state == CMD2) || (state == POLL) ||
                        (state == CLR)  || (state == ARRAY) || (state == RDARR);
  // an ack only counts while our own request is outstanding
  assign ack          = req & br_ack;
  assign gap_ok       = (gap_cnt <= 2'd1);
  assign poll_inc     = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign poll_timeout = (poll_inc >= POLL_MAX);
  assign status_err   = (code_q == 2'b01) ? (br_rdata[4] | br_rdata[3] | br_rdata[1])
                                          : (br_rdata[5] | br_rdata[3] | br_rdata[1]);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (op_start) state_nxt = (op_code == 2'b11) ? DONE : CMD1;
      CMD1:  if (ack) state_nxt = (code_q == 2'b00) ? RDARR : CMD2;
      CMD2:  if (ack) state_nxt = POLL;
      POLL: begin
        if (ack) begin
          if (br_rdata[7])       state_nxt = status_err ? CLR : ARRAY;
          else if (poll_timeout) state_nxt = CLR;
        end
      end
      CLR:   if (ack) state_nxt = ARRAY;
      ARRAY: if (ack) state_nxt = DONE;
      RDARR: if (ack) state_nxt = DONE;
      DONE:  if (gap_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    br_req    = req;
    br_we     = 1'b0;
    br_addr   = bus_state ? addr_q : 8'h00;
    br_wdata  = 8'h00;
    op_busy   = (state != IDLE);
    op_done   = done_q;
    op_err    = err_q;
    op_rdata  = rdata_q;
    op_status = status_q;
    case (state)
      CMD1: begin
        br_we = 1'b1;
        case (code_q)
          2'b01:   br_wdata = 8'h40;
          2'b10:   br_wdata = 8'h20;
          default: br_wdata = 8'hFF;
        endcase
      end
      CMD2: begin
        br_we    = 1'b1;
        br_wdata = (code_q == 2'b01) ? wdata_q : 8'hD0;
      end
      CLR:   begin br_we = 1'b1; br_wdata = 8'h50; end
      ARRAY: begin br_we = 1'b1; br_wdata = 8'hFF; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      code_q   <= 2'b00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      status_q <= 8'h00;
      req      <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      gap_cnt  <= 2'd0;
      poll_cnt <= 16'd0;
    end else begin
      done_q <= (state == DONE) && gap_ok;
      if (state == IDLE && op_start) begin
        code_q  <= op_code;
        addr_q  <= op_addr;
        wdata_q <= op_wdata;
        err_q   <= (op_code == 2'b11);
        gap_cnt <= 2'd0;
      end
      // request rises in the last gap cycle so exactly GAP idle cycles separate requests
      if (ack) begin
        req     <= 1'b0;
        gap_cnt <= GAP;
      end else if (bus_state && !req) begin
        if (gap_ok) req <= 1'b1;
        if (gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;
      end else if (state == DONE && gap_cnt != 2'd0) begin
        gap_cnt <= gap_cnt - 2'd1;
      end
      if (state == CMD2 && ack) poll_cnt <= 16'd0;
      if (state == POLL && ack) begin
        status_q <= br_rdata;
        poll_cnt <= poll_inc;
        if (br_rdata[7])       err_q <= status_err;
        else if (poll_timeout) err_q <= 1'b1;
      end
      if (state == RDARR && ack) rdata_q <= br_rdata;
    end
  end

endmodule
